// File: rtl/dtu_rx_frame_if.sv
// Host-facing message handshake of the DTU receiver.
// The master drives the received message and status; the slave is the host that acknowledges.
interface dtu_rx_frame_if #(
  parameter int unsigned DATA_W = 7
);
  logic              rx_ack;
  logic [DATA_W-1:0] rx_character1;
  logic [DATA_W-1:0] rx_character2;
  logic              rx_busy;
  logic              rx_ready;
  logic              rx_error;

  modport master (
    input  rx_ack,
    output rx_character1,
    output rx_character2,
    output rx_busy,
    output rx_ready,
    output rx_error
  );

  modport slave (
    output rx_ack,
    input  rx_character1,
    input  rx_character2,
    input  rx_busy,
    input  rx_ready,
    input  rx_error
  );
endinterface

// File: rtl/dtu_rx_frame.sv
// DTU asynchronous link receiver: oversampled start/data/parity/stop deserialiser holding a
// two-character message that the host collects through a ready/ack handshake.
module dtu_rx_frame #(
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned DATA_W     = 7
) (
  input  logic              clk_rx,
  input  logic              rst,
  input  logic              en,
  input  logic              clk_div_ld,
  input  logic [1:0]        clk_div_sel,
  input  logic              rx_in,
  dtu_rx_frame_if.master    rx_bus
);

  localparam int unsigned SampW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW  = $clog2(DATA_W);
  localparam logic [SampW-1:0] HalfLast = SampW'(OVERSAMPLE / 2 - 1);
  localparam logic [SampW-1:0] BitLast  = SampW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic              line_prev_q, line_prev_d;
  logic [1:0]        div_q, div_d;
  logic [2:0]        tick_cnt_q, tick_cnt_d;
  logic [SampW-1:0]  samp_q, samp_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              perr_q, perr_d;
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] char1_q, char1_d, char2_q, char2_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;

  logic [2:0] div_max;
  logic       tick;
  logic       stop_evt;
  logic [1:0] count_base;

  // Next-state: synchroniser, prescaler, frame FSM and message buffer.
  always_comb begin
    state_d     = state_q;
    sync1_d     = rx_in;
    sync2_d     = sync1_q;
    line_prev_d = line_prev_q;
    div_d       = div_q;
    tick_cnt_d  = tick_cnt_q;
    samp_d      = samp_q;
    idx_d       = idx_q;
    data_d      = data_q;
    perr_d      = perr_q;
    count_d     = count_q;
    char1_d     = char1_q;
    char2_d     = char2_q;
    error_d     = error_q;
    stop_evt    = 1'b0;
    count_base  = count_q;

    case (div_q)
      2'd0:    div_max = 3'd0;
      2'd1:    div_max = 3'd1;
      2'd2:    div_max = 3'd3;
      default: div_max = 3'd7;
    endcase
    tick = en && (tick_cnt_q == div_max);

    if (clk_div_ld) begin
      div_d      = clk_div_sel;
      tick_cnt_d = 3'd0;
    end else if (en) begin
      tick_cnt_d = tick ? 3'd0 : tick_cnt_q + 3'd1;
    end

    // Line level as seen on the previous tick; a falling edge is detected across ticks.
    if (tick) line_prev_d = sync2_q;

    if (!en) begin
      state_d = StIdle;
      samp_d  = '0;
    end else if (tick) begin
      case (state_q)
        StIdle: begin
          // After a break line_prev stays 0 until the line has returned high.
          if (line_prev_q && !sync2_q) begin
            state_d = StStart;
            samp_d  = '0;
          end
        end
        StStart: begin
          if (samp_q == HalfLast) begin
            samp_d  = '0;
            idx_d   = '0;
            state_d = sync2_q ? StIdle : StData;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
        StData: begin
          if (samp_q == BitLast) begin
            samp_d         = '0;
            data_d[idx_q]  = sync2_q;
            if (idx_q == IdxLast) state_d = StParity;
            else                  idx_d   = idx_q + 1'b1;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
        StParity: begin
          if (samp_q == BitLast) begin
            samp_d  = '0;
            perr_d  = sync2_q ^ (^data_q);
            state_d = StStop;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
        StStop: begin
          if (samp_q == BitLast) begin
            samp_d   = '0;
            stop_evt = 1'b1;
            state_d  = StIdle;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Ack is applied before any commit landing in the same cycle.
    if (rx_bus.rx_ack) begin
      count_base = 2'd0;
      error_d    = 1'b0;
    end
    count_d = count_base;

    if (stop_evt) begin
      if (perr_q || !sync2_q) begin
        error_d = 1'b1;
      end else if (count_base == 2'd0) begin
        char1_d = data_q;
        count_d = 2'd1;
      end else if (count_base == 2'd1) begin
        char2_d = data_q;
        count_d = 2'd2;
      end else begin
        error_d = 1'b1;
      end
    end

    ready_d = (count_d == 2'd2);
  end

  // State registers with synchronous reset; sync flops reset to the idle line level.
  always_ff @(posedge clk_rx) begin
    if (rst) begin
      state_q     <= StIdle;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
      div_q       <= 2'd0;
      tick_cnt_q  <= 3'd0;
      samp_q      <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      perr_q      <= 1'b0;
      count_q     <= 2'd0;
      char1_q     <= '0;
      char2_q     <= '0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      line_prev_q <= line_prev_d;
      div_q       <= div_d;
      tick_cnt_q  <= tick_cnt_d;
      samp_q      <= samp_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      perr_q      <= perr_d;
      count_q     <= count_d;
      char1_q     <= char1_d;
      char2_q     <= char2_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
    end
  end

  assign rx_bus.rx_character1 = char1_q;
  assign rx_bus.rx_character2 = char2_q;
  assign rx_bus.rx_busy       = (state_q != StIdle);
  assign rx_bus.rx_ready      = ready_q;
  assign rx_bus.rx_error      = error_q;

endmodule
